alu: RTL and testbench

//  4-bit registered ALU for the SAP-style datapath. Operand A comes from the

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_if.sv | 31 +++
 rtl/alu_adder4.sv | 23 ++
 rtl/alu.sv | 122 ++++++++++++
 tb/tb_alu.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, op-code enum and strobe priority encoder for the 4-bit ALU.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam logic [ALU_W-1:0] DIV0_QUOT = 4'hF;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_MUL,
    OP_DIV,
    OP_SHL
  } op_e;

  // Fixed priority: add > sub > and > mul > div > shift-left.
  function automatic op_e pick_op(input logic s_add, input logic s_sub,
                                  input logic s_and, input logic s_mul,
                                  input logic s_div, input logic s_shl);
    if (s_add)      return OP_ADD;
    else if (s_sub) return OP_SUB;
    else if (s_and) return OP_AND;
    else if (s_mul) return OP_MUL;
    else if (s_div) return OP_DIV;
    else if (s_shl) return OP_SHL;
    else            return OP_NONE;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand, op-strobe and result/flag bundle between the controller and the ALU.
// Strobes are level-sensitive and need no acknowledge: a strobe high at a rising
// edge executes that op once on that edge; there is no valid/ready handshake.
interface alu_if;
  import alu_pkg::*;

  logic             alu_add;
  logic             alu_sub;
  logic             alu_and;
  logic             alu_mul;
  logic             alu_div;
  logic             al_lsb;
  logic [ALU_W-1:0] AH_in;
  logic [ALU_W-1:0] BREG_in;
  logic [ALU_W-1:0] ALU_out;
  logic             Fa_cout;
  logic             sign_flag;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb, AH_in, BREG_in,
    input  ALU_out, Fa_cout, sign_flag, carry_flag, zero_flag
  );

  modport slave (
    input  alu_add, alu_sub, alu_and, alu_mul, alu_div, al_lsb, AH_in, BREG_in,
    output ALU_out, Fa_cout, sign_flag, carry_flag, zero_flag
  );

endinterface

// File: rtl/alu_adder4.sv
// 4-bit ripple-carry adder built from full adders; shared by add and sub.
module alu_adder4
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic             i_cin,
  output logic [ALU_W-1:0] o_sum,
  output logic             o_cout
);

  logic [ALU_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < ALU_W; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[ALU_W];

endmodule

// File: rtl/alu.sv
// 4-bit registered ALU: priority-encoded op strobes, combinational op units,
// result mux, and result/flag registers with synchronous clear.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic clr,
  alu_if.slave bus
);

  logic [ALU_W-1:0]   w_a;
  logic [ALU_W-1:0]   w_b;
  logic               w_sub_mode;
  logic [ALU_W-1:0]   w_b_eff;
  logic [ALU_W-1:0]   w_sum;
  logic               w_cout;
  logic [2*ALU_W-1:0] w_prod;
  logic [ALU_W:0]     w_rem;
  logic [ALU_W-1:0]   w_quot;
  op_e                w_op;
  logic [ALU_W-1:0]   w_res;
  logic               w_cy;

  logic [ALU_W-1:0]   r_out;
  logic               r_sign;
  logic               r_carry;
  logic               r_zero;

  assign w_a = bus.AH_in;
  assign w_b = bus.BREG_in;

  // The adder follows the raw strobes, not the encoded op, so Fa_cout keeps
  // tracking operands even when clr is high or no op is selected.
  assign w_sub_mode = bus.alu_sub & ~bus.alu_add;
  assign w_b_eff    = w_sub_mode ? ~w_b : w_b;

  alu_adder4 u_adder (
    .i_a    (w_a),
    .i_b    (w_b_eff),
    .i_cin  (w_sub_mode),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign bus.Fa_cout = w_cout;

  assign w_op = pick_op(bus.alu_add, bus.alu_sub, bus.alu_and,
                        bus.alu_mul, bus.alu_div, bus.al_lsb);

  // Shift-and-add multiplier array.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < ALU_W; i++) begin
      if (w_b[i]) w_prod = w_prod + ({{ALU_W{1'b0}}, w_a} << i);
    end
  end

  // Restoring divider array, one trial subtraction per quotient bit.
  always_comb begin
    w_rem  = '0;
    w_quot = '0;
    for (int i = ALU_W - 1; i >= 0; i--) begin
      w_rem = {w_rem[ALU_W-1:0], w_a[i]};
      if (w_rem >= {1'b0, w_b}) begin
        w_rem     = w_rem - {1'b0, w_b};
        w_quot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum;
        w_cy  = w_cout;
      end
      OP_AND: w_res = w_a & w_b;
      OP_MUL: begin
        w_res = w_prod[ALU_W-1:0];
        w_cy  = |w_prod[2*ALU_W-1:ALU_W];
      end
      OP_DIV: begin
        if (w_b == '0) begin
          w_res = DIV0_QUOT;
          w_cy  = 1'b1;
        end else begin
          w_res = w_quot;
        end
      end
      OP_SHL: begin
        w_res = {w_a[ALU_W-2:0], 1'b0};
        w_cy  = w_a[ALU_W-1];
      end
      default: begin
        w_res = '0;
        w_cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_out   <= '0;
      r_sign  <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_op != OP_NONE) begin
      r_out   <= w_res;
      r_sign  <= w_res[ALU_W-1];
      r_carry <= w_cy;
      r_zero  <= (w_res == '0);
    end
  end

  assign bus.ALU_out    = r_out;
  assign bus.sign_flag  = r_sign;
  assign bus.carry_flag = r_carry;
  assign bus.zero_flag  = r_zero;

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for the 4-bit registered ALU.
module tb_alu;

  logic clk;
  logic clr;
  alu_if bus ();

  alu dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  // ops bits: {add, sub, and, mul, div, shl}
  typedef struct {
    string      name;
    logic [5:0] ops;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_out;
    logic       exp_s;
    logic       exp_c;
    logic       exp_z;
    logic       exp_fa;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ops, input logic [3:0] a, input logic [3:0] b);
    bus.alu_add = ops[5];
    bus.alu_sub = ops[4];
    bus.alu_and = ops[3];
    bus.alu_mul = ops[2];
    bus.alu_div = ops[1];
    bus.al_lsb  = ops[0];
    bus.AH_in   = a;
    bus.BREG_in = b;
  endtask

  task automatic check_regs(input string name, input logic [3:0] e_out,
                            input logic e_s, input logic e_c, input logic e_z);
    logic [3:0] exp_out;
    exp_q.push_back(e_out);
    exp_out = exp_q.pop_front();
    chk({name, ".out"},   bus.ALU_out, exp_out);
    chk({name, ".sign"},  {3'b0, bus.sign_flag},  {3'b0, e_s});
    chk({name, ".carry"}, {3'b0, bus.carry_flag}, {3'b0, e_c});
    chk({name, ".zero"},  {3'b0, bus.zero_flag},  {3'b0, e_z});
  endtask

  // Drive at negedge, check Fa_cout combinationally, then check regs after posedge.
  task automatic step(input string name, input logic [5:0] ops, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] e_out, input logic e_s,
                      input logic e_c, input logic e_z, input logic e_fa);
    @(negedge clk);
    drive(ops, a, b);
    #1;
    chk({name, ".fa_cout"}, {3'b0, bus.Fa_cout}, {3'b0, e_fa});
    @(posedge clk);
    #1;
    check_regs(name, e_out, e_s, e_c, e_z);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{"add_5_2",     6'b100000, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"sub_5_2",     6'b010000, 4'h5, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"sub_2_5",     6'b010000, 4'h2, 4'h5, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"and_5_2",     6'b001000, 4'h5, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"idle_hold",   6'b000000, 4'h5, 4'h2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"mul_5_2",     6'b000100, 4'h5, 4'h2, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"mul_6_3",     6'b000100, 4'h6, 4'h3, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"div_5_2",     6'b000010, 4'h5, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"div_5_0",     6'b000010, 4'h5, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"shl_9",       6'b000001, 4'h9, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"add_sub_pri", 6'b110000, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"add_9_8",     6'b100000, 4'h9, 4'h8, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{"div_15_1",    6'b000010, 4'hF, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{"mul_div_pri", 6'b000110, 4'h3, 4'h3, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"sub_7_7",     6'b010000, 4'h7, 4'h7, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};

    drive(6'b000000, 4'h5, 4'h2);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_regs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check_regs("reset_idle", 4'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].name, vecs[i].ops, vecs[i].a, vecs[i].b, vecs[i].exp_out,
           vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_z, vecs[i].exp_fa);
    end

    // Held strobe re-executes each edge with the operands present at that edge.
    step("held_add_1", 6'b100000, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    step("held_add_2", 6'b100000, 4'h3, 4'h1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    step("held_add_3", 6'b100000, 4'hF, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Nonzero state, then clr together with add: clr wins, Fa_cout ignores clr.
    step("pre_clr", 6'b000001, 4'hC, 4'h0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    drive(6'b100000, 4'h9, 4'h8);
    #1;
    chk("clr_add.fa_cout", {3'b0, bus.Fa_cout}, 4'h1);
    @(posedge clk);
    #1;
    check_regs("clr_add", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    drive(6'b000000, 4'h9, 4'h8);
    @(posedge clk);
    #1;
    check_regs("post_clr_idle", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
